// File: rtl/acc_pkg.sv
// acc_pkg: shared op codes, state encoding and saturation limits for the
// accumulator core and its sequential multiplier.
package acc_pkg;

  // Operation codes presented on the op port
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_OUT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CLR = 4'd9;

  // Control state encoding; any other value is treated as illegal
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;

  // Largest positive two's-complement value of a w-bit word (0111..1)
  function automatic logic [31:0] sat_max(input int unsigned w);
    return (32'h1 << (w - 1)) - 32'h1;
  endfunction

  // Most negative two's-complement value of a w-bit word (1000..0)
  function automatic logic [31:0] sat_min(input int unsigned w);
    return 32'h1 << (w - 1);
  endfunction

endpackage

// File: rtl/acc_mul_seq.sv
// acc_mul_seq: shift-add unsigned multiplier. Loads on start, then runs
// exactly WIDTH iterations; fin is high during the last one and product
// carries the completed low WIDTH bits in that same cycle.
module acc_mul_seq
  import acc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic [SHW-1:0]   cnt;
  logic             last;

  assign addend  = mplier[0] ? mcand : '0;
  assign sum     = partial + addend;
  assign last    = (cnt == SHW'(WIDTH - 1));
  assign fin     = busy && last;
  // The final iteration's sum is the result, so the core can capture it on
  // the same edge that ends the run.
  assign product = sum;

  // Control: busy flag and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (last) begin
        busy <= 1'b0;
      end
      cnt <= cnt + 1'b1;
    end
  end

  // Datapath: operand load and one shift-add step per busy cycle
  always_ff @(posedge clk) begin
    if (start) begin
      mcand   <= mcand_in;
      mplier  <= mplier_in;
      partial <= '0;
    end else if (busy) begin
      partial <= sum;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
    end
  end

endmodule

// File: rtl/acc_core_p.sv
// acc_core_p: WIDTH-bit accumulator with valid/ready op interface, single-cycle
// ALU ops, a sequential multiply, status flags and a registered Output latch.
// Build option: define ACC_SAT_EN to make ADD/SUB saturate as signed values
// (default build wraps modulo 2^WIDTH).
module acc_core_p
  import acc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] IOIn,
  input  logic [3:0]       op,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             done,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] acc_q,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_fin;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             c_nxt;
  logic             out_we;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;

  assign sum_w = {1'b0, acc} + {1'b0, IOIn};
  assign diff  = acc - IOIn;
  // Bit WIDTH of the widened shift is the last bit pushed out of the word;
  // it is naturally 0 for a zero shift amount.
  assign shl_w = {1'b0, acc} << IOIn[SHW-1:0];

`ifdef ACC_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  logic signed [WIDTH-1:0] acc_s;
  logic signed [WIDTH-1:0] opnd_s;

  assign acc_s  = acc;
  assign opnd_s = IOIn;

  // On signed overflow the true result lies beyond the limit on the side of a's sign
  function automatic logic [WIDTH-1:0] clamp(input logic ovf,
                                              input logic signed [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] r);
    if (!ovf) return r;
    return a[WIDTH-1] ? SAT_MIN : SAT_MAX;
  endfunction

  function automatic logic [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] r);
    return clamp((a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]), a, r);
  endfunction

  function automatic logic [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] r);
    return clamp((a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]), a, r);
  endfunction

  assign add_res = sat_add(acc_s, opnd_s, sum_w[WIDTH-1:0]);
  assign sub_res = sat_sub(acc_s, opnd_s, diff);
`else
  assign add_res = sum_w[WIDTH-1:0];
  assign sub_res = diff;
`endif

  // FSM state register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; MUL also falls back to IDLE if the multiplier is not running
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = mul_start ? ST_MUL : ST_IDLE;
      ST_MUL:  state_nxt = (mul_busy && !mul_fin) ? ST_MUL : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake and multiplier launch
  always_comb begin
    op_ready  = (state == ST_IDLE);
    accept    = op_valid && op_ready;
    mul_start = accept && (op == OP_MUL);
  end

  // Single-cycle ALU result and carry for the op being offered
  always_comb begin
    acc_nxt = acc;
    c_nxt   = flag_c;
    out_we  = 1'b0;
    case (op)
      OP_LDI: acc_nxt = IOIn;
      OP_ADD: begin
        acc_nxt = add_res;
        c_nxt   = sum_w[WIDTH];
      end
      OP_SUB: begin
        acc_nxt = sub_res;
        c_nxt   = (acc >= IOIn);
      end
      OP_AND: acc_nxt = acc & IOIn;
      OP_OR:  acc_nxt = acc | IOIn;
      OP_SLL: begin
        acc_nxt = shl_w[WIDTH-1:0];
        c_nxt   = shl_w[WIDTH];
      end
      OP_OUT: out_we = 1'b1;
      OP_CLR: begin
        acc_nxt = '0;
        c_nxt   = 1'b0;
      end
      default: ;
    endcase
  end

  acc_mul_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mul (
    .clk       (CLK),
    .rst       (reset),
    .start     (mul_start),
    .mcand_in  (acc),
    .mplier_in (IOIn),
    .busy      (mul_busy),
    .fin       (mul_fin),
    .product   (mul_prod)
  );

  // Architectural registers: accumulator, carry, Output latch and done pulse
  always_ff @(posedge CLK) begin
    if (reset) begin
      acc    <= '0;
      Output <= '0;
      flag_c <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (accept && (op != OP_MUL)) || mul_fin;
      if (mul_fin) begin
        acc <= mul_prod;
      end else if (accept) begin
        acc    <= acc_nxt;
        flag_c <= c_nxt;
        if (out_we) begin
          Output <= acc;
        end
      end
    end
  end

  assign acc_q  = acc;
  assign flag_z = (acc == '0);
  assign flag_n = acc[WIDTH-1];

endmodule

// File: tb/tb_acc_core_p.sv
// tb_acc_core_p: directed stimulus for acc_core_p (WIDTH=16) with a
// transaction-level reference model compared every cycle, plus literal
// expectations for the listed scenarios.
module tb_acc_core_p;

  localparam int W   = 16;
  localparam int SHW = 4;

  localparam logic [3:0] NOP = 4'd0, LDI = 4'd1, ADD = 4'd2, SUB = 4'd3, AND_ = 4'd4,
                         OR_ = 4'd5, SLL = 4'd6, OUT = 4'd7, MUL = 4'd8, CLR = 4'd9;

  logic         CLK = 1'b0;
  logic         reset;
  logic [W-1:0] IOIn;
  logic [3:0]   op;
  logic         op_valid;
  logic         op_ready;
  logic         done;
  logic [W-1:0] Output;
  logic [W-1:0] acc_q;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  acc_core_p #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .IOIn     (IOIn),
    .op       (op),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .done     (done),
    .Output   (Output),
    .acc_q    (acc_q),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state advanced once per clock
  logic [W-1:0] m_acc, m_out, m_prod;
  logic         m_c, m_done;
  int           m_busy;
  longint       s, ss;
  int           amt;
  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (W - 1));

  always @(posedge CLK) begin
    if (reset) begin
      m_acc = '0; m_out = '0; m_c = 1'b0; m_done = 1'b0; m_busy = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_acc  = m_prod;
          m_done = 1'b1;
        end
      end else if (op_valid) begin
        m_done = 1'b1;
        case (op)
          LDI: m_acc = IOIn;
          ADD: begin
            s   = longint'(m_acc) + longint'(IOIn);
            m_c = (s >= (64'sd1 <<< W));
`ifdef ACC_SAT_EN
            ss = longint'($signed(m_acc)) + longint'($signed(IOIn));
            if (ss > SMAX) ss = SMAX;
            else if (ss < SMIN) ss = SMIN;
            m_acc = ss[W-1:0];
`else
            m_acc = s[W-1:0];
`endif
          end
          SUB: begin
            m_c = (m_acc >= IOIn);
            s   = longint'(m_acc) - longint'(IOIn);
`ifdef ACC_SAT_EN
            ss = longint'($signed(m_acc)) - longint'($signed(IOIn));
            if (ss > SMAX) ss = SMAX;
            else if (ss < SMIN) ss = SMIN;
            m_acc = ss[W-1:0];
`else
            m_acc = s[W-1:0];
`endif
          end
          AND_: m_acc = m_acc & IOIn;
          OR_:  m_acc = m_acc | IOIn;
          SLL: begin
            amt   = int'(IOIn[SHW-1:0]);
            m_c   = (amt == 0) ? 1'b0 : m_acc[W-amt];
            m_acc = m_acc << amt;
          end
          OUT: m_out = m_acc;
          MUL: begin
            s      = longint'(m_acc) * longint'(IOIn);
            m_prod = s[W-1:0];
            m_busy = W;
            m_done = 1'b0;
          end
          CLR: begin
            m_acc = '0;
            m_c   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      check("acc_q",    32'(acc_q),    32'(m_acc));
      check("Output",   32'(Output),   32'(m_out));
      check("flag_z",   32'(flag_z),   32'(m_acc == '0));
      check("flag_n",   32'(flag_n),   32'(m_acc[W-1]));
      check("flag_c",   32'(flag_c),   32'(m_c));
      check("done",     32'(done),     32'(m_done));
      check("op_ready", 32'(op_ready), 32'(m_busy == 0));
    end
  end

  // Offer one op at a negedge and return at the negedge after it is accepted
  task automatic send(input logic [3:0] o, input logic [W-1:0] v);
    int n = 0;
    op_valid = 1'b1; op = o; IOIn = v;
    while (!op_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!op_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: op %0d not accepted after %0d cycles", o, n);
    end
    @(negedge CLK);
    op_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lows;
    reset = 1'b1; op_valid = 1'b0; op = '0; IOIn = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_acc",   32'(acc_q),    32'h0);
    check("rst_ready", 32'(op_ready), 32'h1);
    check("rst_z",     32'(flag_z),   32'h1);

    // LDI then ADD with carry to zero
    send(LDI, 16'hff00);
    send(ADD, 16'h0100);
    check("t1_acc",  32'(acc_q),  32'h0000);
    check("t1_c",    32'(flag_c), 32'h1);
    check("t1_z",    32'(flag_z), 32'h1);
    check("t1_done", 32'(done),   32'h1);

    // Multiply latency and Output latch
    send(LDI, 16'h0003);
    send(MUL, 16'h0005);
    n = 1; lows = 0;
    while (!done && n < 40) begin
      if (!op_ready) lows++;
      @(negedge CLK);
      n++;
    end
    check("t2_latency",  32'(n),      32'd17);
    check("t2_readylow", 32'(lows),   32'd16);
    check("t2_acc",      32'(acc_q),  32'h000f);
    check("t2_out_hold", 32'(Output), 32'h0000);
    send(OUT, 16'h0000);
    check("t2_out",      32'(Output), 32'h000f);

    // Back-to-back LDI / SUB / OUT
    send(LDI, 16'h1234);
    send(SUB, 16'h1235);
    check("t3_acc", 32'(acc_q),  32'hffff);
    check("t3_c",   32'(flag_c), 32'h0);
    check("t3_n",   32'(flag_n), 32'h1);
    send(OUT, 16'h0000);
    check("t3_out", 32'(Output), 32'hffff);

    // Reset in the middle of a multiply
    send(LDI, 16'h0003);
    send(MUL, 16'h0005);
    repeat (7) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    check("t4_acc",   32'(acc_q),    32'h0000);
    check("t4_ready", 32'(op_ready), 32'h1);
    check("t4_done",  32'(done),     32'h0);
    check("t4_out",   32'(Output),   32'h0000);
    send(LDI, 16'h0042);
    check("t4_ldi", 32'(acc_q), 32'h0042);

    // Signed overflow boundary
    send(LDI, 16'h7fff);
    send(ADD, 16'h0001);
`ifdef ACC_SAT_EN
    check("t5_acc", 32'(acc_q), 32'h7fff);
`else
    check("t5_acc", 32'(acc_q),  32'h8000);
    check("t5_n",   32'(flag_n), 32'h1);
`endif
    send(LDI, 16'h8000);
    send(SUB, 16'h0001);
    check("t5_subc", 32'(flag_c), 32'h1);

    // Shift carry and unused op codes
    send(LDI, 16'h8001);
    send(SLL, 16'h0001);
    check("t6_acc", 32'(acc_q),  32'h0002);
    check("t6_c",   32'(flag_c), 32'h1);
    send(4'hf, 16'h1234);
    check("t6_nop_acc",  32'(acc_q),  32'h0002);
    check("t6_nop_done", 32'(done),   32'h1);
    send(SLL, 16'h0010);
    check("t6_sll0_c", 32'(flag_c), 32'h0);

    // Logic ops, carry from ADD, CLR
    send(LDI,  16'hf0f0);
    send(AND_, 16'h3c3c);
    check("t7_and", 32'(acc_q), 32'h3030);
    send(OR_,  16'h0101);
    check("t7_or", 32'(acc_q), 32'h3131);
    send(ADD,  16'hffff);
    check("t7_add",  32'(acc_q),  32'h3130);
    check("t7_addc", 32'(flag_c), 32'h1);
    send(CLR,  16'h5555);
    check("t7_clr",  32'(acc_q),  32'h0000);
    check("t7_clrc", 32'(flag_c), 32'h0);
    send(NOP, 16'h0000);
    send(4'hb, 16'hffff);

    // Equal SUB, larger multiplies, multiply followed immediately by another op
    send(LDI, 16'h0005);
    send(SUB, 16'h0005);
    check("t8_subc", 32'(flag_c), 32'h1);
    send(LDI, 16'hffff);
    send(MUL, 16'hffff);
    send(OUT, 16'h0000);
    check("t8_mulffff", 32'(Output), 32'h0001);
    send(LDI, 16'h1234);
    send(MUL, 16'h5678);
    send(ADD, 16'h0000);
    check("t8_mul", 32'(acc_q), 32'h0060);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
